seg_scan_driver: RTL and testbench

//   Display-side consumer of the stopwatch BCD counter chain.
//   - Snapshots NUM_DIGITS BCD digits on a load strobe.
//   - Applies the snapshot only at frame boundaries, so the display never tears mid-frame.
//   - Time-multiplexes the digits onto one shared 7-segment bus.
//   - Inserts a blanking gap between digits to suppress ghosting.

---
 rtl/seg_scan_driver.sv | 169 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 121 ++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 7-segment scan driver for the stopwatch BCD chain.
// A load strobe captures the digits into a pending shadow. The pending shadow moves
// into the active shadow only at the frame boundary, so a frame never mixes old and
// new digits. Each digit slot starts with a blanking gap, then drives that digit's
// common line.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seg_scan_driver #(
  parameter int NUM_DIGITS     = 6,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int COM_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   com,
  output logic                    frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW != 0}};
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] COM_OFF = {NUM_DIGITS{COM_ACTIVE_LOW != 0}};

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                    act_v_q, act_v_d, pend_v_q, pend_v_d;
  logic                    boundary;
  logic [NUM_DIGITS-1:0]   lz;
  logic [6:0]              seg_d;
  logic                    dp_d, fd_d;
  logic [NUM_DIGITS-1:0]   com_d;

  function automatic logic [6:0] bcd7(input logic [3:0] d);
    case (d)
      4'd0:    bcd7 = 7'h3F;
      4'd1:    bcd7 = 7'h06;
      4'd2:    bcd7 = 7'h5B;
      4'd3:    bcd7 = 7'h4F;
      4'd4:    bcd7 = 7'h66;
      4'd5:    bcd7 = 7'h6D;
      4'd6:    bcd7 = 7'h7D;
      4'd7:    bcd7 = 7'h07;
      4'd8:    bcd7 = 7'h7F;
      4'd9:    bcd7 = 7'h6F;
      default: bcd7 = 7'h40;
    endcase
  endfunction

  // Slot sequencing and pending/active snapshot handling.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    act_dig_d  = act_dig_q;
    act_dp_d   = act_dp_q;
    act_v_d    = act_v_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_v_d   = pend_v_q;
    boundary   = (state_q == S_DRIVE) && (presc_q == PRE_LAST) && (idx_q == IDX_LAST);
    presc_d    = (presc_q == PRE_LAST) ? '0 : presc_q + 1'b1;
    case (state_q)
      S_BLANK: if (presc_q == BLANK_LAST) state_d = S_DRIVE;
      S_DRIVE: if (presc_q == PRE_LAST) begin
        state_d = S_BLANK;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      default: state_d = S_BLANK;
    endcase
    if (boundary) begin
      // A load on the boundary edge supersedes anything still pending.
      if (load) begin
        act_dig_d = digits_in;
        act_dp_d  = dp_in;
        act_v_d   = 1'b1;
      end else if (pend_v_q) begin
        act_dig_d = pend_dig_q;
        act_dp_d  = pend_dp_q;
        act_v_d   = 1'b1;
      end
      pend_v_d = 1'b0;
    end else if (load) begin
      pend_dig_d = digits_in;
      pend_dp_d  = dp_in;
      pend_v_d   = 1'b1;
    end
  end

  // Leading-zero map: lz[k] set when digit k and all digits above it are zero.
  always_comb begin
    logic above;
    lz    = '0;
    above = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      above = above && (act_dig_d[4*(NUM_DIGITS-1-j) +: 4] == 4'd0);
      lz[NUM_DIGITS-1-j] = above;
    end
`endif
  end

  // Output values for the state being entered, so registered outputs carry no extra lag.
  // Until the first snapshot reaches the active shadow the segments stay dark.
  always_comb begin
    logic [6:0] seg_hi;
    logic       dp_hi;
    seg_hi = 7'h00;
    dp_hi  = 1'b0;
    com_d  = COM_OFF;
    if (state_d == S_DRIVE) begin
      com_d[idx_d] = (COM_ACTIVE_LOW == 0);
      if (act_v_d) begin
        seg_hi = (lz[idx_d] && (idx_d != '0)) ? 7'h00 : bcd7(act_dig_d[{idx_d, 2'b00} +: 4]);
        dp_hi  = act_dp_d[idx_d];
      end
    end
    seg_d = seg_hi ^ SEG_OFF;
    dp_d  = dp_hi ^ DP_OFF;
    fd_d  = (presc_d == PRE_LAST) && (idx_d == IDX_LAST);
  end

  // State, shadows and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BLANK;
      presc_q    <= '0;
      idx_q      <= '0;
      act_dig_q  <= '0;
      act_dp_q   <= '0;
      act_v_q    <= 1'b0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      pend_v_q   <= 1'b0;
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      com        <= COM_OFF;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      act_dig_q  <= act_dig_d;
      act_dp_q   <= act_dp_d;
      act_v_q    <= act_v_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      pend_v_q   <= pend_v_d;
      seg        <= seg_d;
      dp         <= dp_d;
      com        <= com_d;
      frame_done <= fd_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4 digits, 8-clock slots with a 2-clock blank,
// and active-high segment and common outputs.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  com;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .SEG_ACTIVE_LOW(0), .COM_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .seg(seg), .dp(dp), .com(com), .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stops on the negedge inside the last clock of a frame (frame_done high).
  task automatic wait_boundary();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      hit = (frame_done === 1'b1);
    end
    check("boundary_seen", 32'(hit), 32'd1);
  endtask

  // Checks one full frame clock by clock; optional loads are issued at cycles la/lb
  // (captured on the following edge; lb=31 lands on the next boundary edge).
  task automatic run_frame(input string tag,
                           input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input logic [6:0] e3,
                           input logic [3:0] edp,
                           input int la, input logic [15:0] da, input logic [3:0] pa,
                           input int lb, input logic [15:0] db, input logic [3:0] pb);
    logic [6:0] es [4];
    logic [3:0] ecom;
    logic [6:0] eseg;
    logic       edpv;
    int         slot, p;
    es[0] = e0; es[1] = e1; es[2] = e2; es[3] = e3;
    for (int c = 0; c < 32; c++) begin
      @(posedge clk); #1;
      load = 1'b0;
      slot = c / 8;
      p    = c % 8;
      if (p < 2) begin
        ecom = 4'b0000; eseg = 7'h00; edpv = 1'b0;
      end else begin
        ecom = 4'b0001 << slot; eseg = es[slot]; edpv = edp[slot];
      end
      check($sformatf("%s c%0d com", tag, c), 32'(com), 32'(ecom));
      check($sformatf("%s c%0d seg", tag, c), 32'(seg), 32'(eseg));
      check($sformatf("%s c%0d dp", tag, c), 32'(dp), 32'(edpv));
      check($sformatf("%s c%0d frame_done", tag, c), 32'(frame_done), 32'(c == 31));
      if (c == la) begin digits_in = da; dp_in = pa; load = 1'b1; end
      if (c == lb) begin digits_in = db; dp_in = pb; load = 1'b1; end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset com", 32'(com), 32'h0);
    check("reset seg", 32'(seg), 32'h0);
    check("reset dp", 32'(dp), 32'h0);
    check("reset frame_done", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    wait_boundary();
    run_frame("t1_blank", 7'h00, 7'h00, 7'h00, 7'h00, 4'b0000, 10, 16'h1234, 4'b0000, -1, 16'h0, 4'b0);
    run_frame("t1_scan",  7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0000, 19, 16'h9999, 4'b0000, -1, 16'h0, 4'b0);
    run_frame("t2_9999",  7'h6F, 7'h6F, 7'h6F, 7'h6F, 4'b0000, 5, 16'h1111, 4'b0000, 31, 16'h2222, 4'b0000);
    run_frame("t3_2222",  7'h5B, 7'h5B, 7'h5B, 7'h5B, 4'b0000, -1, 16'h0, 4'b0, -1, 16'h0, 4'b0);
    run_frame("t3_hold",  7'h5B, 7'h5B, 7'h5B, 7'h5B, 4'b0000, 10, 16'hA0F3, 4'b0100, -1, 16'h0, 4'b0);
    run_frame("t4_nonbcd", 7'h4F, 7'h40, 7'h3F, 7'h40, 4'b0100, 10, 16'h0050, 4'b0000, -1, 16'h0, 4'b0);
`ifdef LEADING_ZERO_BLANK_EN
    run_frame("t6_lzb",   7'h3F, 7'h6D, 7'h00, 7'h00, 4'b0000, -1, 16'h0, 4'b0, -1, 16'h0, 4'b0);
`else
    run_frame("t6_nolzb", 7'h3F, 7'h6D, 7'h3F, 7'h3F, 4'b0000, -1, 16'h0, 4'b0, -1, 16'h0, 4'b0);
`endif

    // Reset while digit 2 is being driven.
    repeat (21) begin @(posedge clk); #1; end
    check("t5 pre com", 32'(com), 32'h4);
    rst_n = 1'b0;
    #1;
    check("t5 async com", 32'(com), 32'h0);
    check("t5 async seg", 32'(seg), 32'h0);
    check("t5 async dp", 32'(dp), 32'h0);
    check("t5 async frame_done", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_boundary();
    run_frame("t5_blank",  7'h00, 7'h00, 7'h00, 7'h00, 4'b0000, 10, 16'h1234, 4'b0000, -1, 16'h0, 4'b0);
    run_frame("t5_reload", 7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0000, -1, 16'h0, 4'b0, -1, 16'h0, 4'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
